// File: rtl/bcd_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_timer_pkg
//  Brief    : Shared constants and helpers for the BCD timer (digit width,
//             seven-segment glyph table, digit clamp).
//  Revision : 1.0  initial release
// ============================================================================
package bcd_timer_pkg;

    localparam int DIG_W = 4;

    // Active-high glyphs, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] seg_encode(input logic [DIG_W-1:0] d);
        if (d <= 4'd9) return SEG_DIGIT[d];
        return SEG_BLANK;
    endfunction

    function automatic logic [DIG_W-1:0] bcd_clamp(input logic [DIG_W-1:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_timer_step.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_step
//  Brief    : One BCD digit of the count chain: +1 or -1 when carry/borrow in,
//             with carry/borrow out on 9->0 or 0->9.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_step
    import bcd_timer_pkg::*;
(
    input  logic [DIG_W-1:0] digit_in,
    input  logic             down,
    input  logic             cin,
    output logic [DIG_W-1:0] digit_out,
    output logic             cout
);

    always_comb begin
        digit_out = digit_in;
        cout      = 1'b0;
        if (cin) begin
            if (!down) begin
                if (digit_in >= 4'd9) begin
                    digit_out = 4'd0;
                    cout      = 1'b1;
                end else begin
                    digit_out = digit_in + 1'b1;
                end
            end else begin
                if (digit_in == 4'd0) begin
                    digit_out = 4'd9;
                    cout      = 1'b1;
                end else begin
                    digit_out = digit_in - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_timer.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_timer
//  Brief    : N-digit BCD up/down timer with lap hold and a multiplexed
//             active-low seven-segment scanner.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_timer
    import bcd_timer_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 800000,
    parameter int LAP_HOLD = 20,
    parameter int SCAN_DIV = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      clear,
    input  logic                      lap,
    input  logic                      load,
    input  logic                      down,
    input  logic [DIG_W*DIGITS-1:0]   load_value,
    output logic [DIG_W*DIGITS-1:0]   value,
    output logic [DIG_W*DIGITS-1:0]   shown,
    output logic                      running,
    output logic                      wrap,
    output logic                      done,
    output logic [6:0]                seg,
    output logic [DIGITS-1:0]         dig_sel
);

    localparam int c_VW = DIG_W * DIGITS;
    localparam int c_PW = $clog2(TICK_DIV);
    localparam int c_SW = $clog2(SCAN_DIV);
    localparam int c_IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_HW = $clog2(LAP_HOLD + 1);

    localparam logic [c_PW-1:0]   c_PRESC_MAX = c_PW'(TICK_DIV - 1);
    localparam logic [c_SW-1:0]   c_SCAN_MAX  = c_SW'(SCAN_DIV - 1);
    localparam logic [c_IW-1:0]   c_IDX_MAX   = c_IW'(DIGITS - 1);
    localparam logic [c_HW-1:0]   c_HOLD_INIT = c_HW'(LAP_HOLD);
    localparam logic [DIGITS-1:0] c_SEL_ONE   = DIGITS'(1);

    logic [c_PW-1:0]   r_presc;
    logic [c_VW-1:0]   r_value;
    logic [c_VW-1:0]   r_lap;
    logic [c_HW-1:0]   r_hold;
    logic              r_running;
    logic              r_wrap;
    logic              r_done;
    logic [c_SW-1:0]   r_scan;
    logic              r_scan_stb;
    logic [c_IW-1:0]   r_idx;
    logic [6:0]        r_seg;
    logic [DIGITS-1:0] r_dig_sel;

    logic              w_tick;
    logic              w_start_acc;
    logic              w_count;
    logic [c_VW-1:0]   w_next;
    logic [c_VW-1:0]   w_load_clamped;
    logic [DIGITS:0]   w_carry;
    logic [c_VW-1:0]   w_shown;
    logic [DIG_W-1:0]  w_cur_digit;

    assign w_tick      = (r_presc == c_PRESC_MAX);
    assign w_start_acc = start & ~clear & ~load & ~stop & ~r_running
                       & ~(down & (r_value == '0));
    assign w_count     = w_tick & r_running & ~clear & ~load & ~stop;
    assign w_carry[0]  = w_count;

    // Ripple chain: digit i steps only when every lower digit wrapped
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_step u_step (
            .digit_in  (r_value[i*DIG_W +: DIG_W]),
            .down      (down),
            .cin       (w_carry[i]),
            .digit_out (w_next[i*DIG_W +: DIG_W]),
            .cout      (w_carry[i+1])
        );
        assign w_load_clamped[i*DIG_W +: DIG_W] = bcd_clamp(load_value[i*DIG_W +: DIG_W]);
    end

    assign w_shown     = (r_hold != '0) ? r_lap : r_value;
    assign w_cur_digit = w_shown[r_idx*DIG_W +: DIG_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc   <= '0;
            r_value   <= '0;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
            r_presc <= (w_start_acc || w_tick) ? '0 : r_presc + 1'b1;
            if (clear) begin
                r_value   <= '0;
                r_running <= 1'b0;
            end else if (load) begin
                r_value <= w_load_clamped;
            end else if (stop) begin
                r_running <= 1'b0;
            end else if (w_start_acc) begin
                r_running <= 1'b1;
            end else if (w_count) begin
                r_value <= w_next;
                if (!down && w_carry[DIGITS]) begin
                    r_wrap <= 1'b1;
                end
                if (down && (w_next == '0)) begin
                    r_done    <= 1'b1;
                    r_running <= 1'b0;
                end
            end
        end
    end

    // Lap captures the pre-update count; the hold ages on every raw tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lap  <= '0;
            r_hold <= '0;
        end else if (clear) begin
            r_hold <= '0;
        end else if (lap) begin
            r_lap  <= r_value;
            r_hold <= c_HOLD_INIT;
        end else if (w_tick && (r_hold != '0)) begin
            r_hold <= r_hold - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan     <= '0;
            r_scan_stb <= 1'b0;
            r_idx      <= '0;
            r_seg      <= ~SEG_BLANK;
            r_dig_sel  <= '0;
        end else begin
            r_scan     <= (r_scan == c_SCAN_MAX) ? '0 : r_scan + 1'b1;
            r_scan_stb <= (r_scan == c_SCAN_MAX);
            if (r_scan_stb) begin
                r_dig_sel <= c_SEL_ONE << r_idx;
                r_seg     <= ~seg_encode(w_cur_digit);
                r_idx     <= (r_idx == c_IDX_MAX) ? '0 : r_idx + 1'b1;
            end
        end
    end

    assign value   = r_value;
    assign shown   = w_shown;
    assign running = r_running;
    assign wrap    = r_wrap;
    assign done    = r_done;
    assign seg     = r_seg;
    assign dig_sel = r_dig_sel;

endmodule
`default_nettype wire

// File: tb/tb_bcd_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_timer
//  Brief    : Directed scenarios plus random commands for bcd_timer, compared
//             every cycle against an integer-arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd_timer;

    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 4;
    localparam int LAP_HOLD = 3;
    localparam int SCAN_DIV = 4;
    localparam int VW       = 4 * DIGITS;

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic lap = 1'b0, load = 1'b0, down = 1'b0;
    logic [VW-1:0]     load_value = '0;
    logic [VW-1:0]     value, shown;
    logic              running, wrap, done;
    logic [6:0]        seg;
    logic [DIGITS-1:0] dig_sel;

    bcd_timer #(
        .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .LAP_HOLD(LAP_HOLD), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .lap(lap), .load(load), .down(down), .load_value(load_value),
        .value(value), .shown(shown), .running(running), .wrap(wrap),
        .done(done), .seg(seg), .dig_sel(dig_sel)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: plain decimal integers
    int m_val = 0, m_lap = 0, m_hold = 0, m_presc = 0, m_n = 0;
    bit m_run = 0, m_wrap = 0, m_done = 0;
    int m_hist[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int to_bcd(input int v);
        int r = 0;
        for (int i = 0; i < DIGITS; i++) begin
            r = r | ((v % 10) << (4 * i));
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int digit_of(input int v, input int idx);
        for (int i = 0; i < idx; i++) v = v / 10;
        return v % 10;
    endfunction

    function automatic int shown_int();
        return (m_hold != 0) ? m_lap : m_val;
    endfunction

    task automatic model_edge();
        bit tick, acc;
        int old, lv, mul;
        if (rst) begin
            m_val = 0; m_lap = 0; m_hold = 0; m_presc = 0; m_n = 0;
            m_run = 0; m_wrap = 0; m_done = 0;
            m_hist.delete();
            m_hist.push_back(0);
            return;
        end
        tick = (m_presc == TICK_DIV - 1);
        old  = m_val;
        acc  = start && !clear && !load && !stop && !m_run && !(down && m_val == 0);
        m_wrap = 0;
        m_done = 0;
        m_presc = acc ? 0 : (m_presc + 1) % TICK_DIV;
        if (clear) begin
            m_val = 0; m_run = 0;
        end else if (load) begin
            lv = 0; mul = 1;
            for (int i = 0; i < DIGITS; i++) begin
                lv  = lv + (((load_value >> (4 * i)) & 15) > 9 ? 9 : ((load_value >> (4 * i)) & 15)) * mul;
                mul = mul * 10;
            end
            m_val = lv;
        end else if (stop) begin
            m_run = 0;
        end else if (acc) begin
            m_run = 1;
        end else if (tick && m_run) begin
            if (!down) begin
                m_val = m_val + 1;
                if (m_val == mul_max()) begin m_val = 0; m_wrap = 1; end
            end else begin
                m_val = (m_val + mul_max() - 1) % mul_max();
                if (m_val == 0) begin m_done = 1; m_run = 0; end
            end
        end
        if (clear) m_hold = 0;
        else if (lap) begin m_lap = old; m_hold = LAP_HOLD; end
        else if (tick && m_hold > 0) m_hold = m_hold - 1;
        m_n++;
        m_hist.push_back(shown_int());
    endtask

    function automatic int mul_max();
        int r = 1;
        for (int i = 0; i < DIGITS; i++) r = r * 10;
        return r;
    endfunction

    task automatic check_all();
        logic [DIGITS-1:0] es;
        logic [6:0]        eg;
        int k, idx;
        es = '0;
        eg = 7'h7F;
        if (m_n >= SCAN_DIV + 1) begin
            k   = (m_n - SCAN_DIV - 1) / SCAN_DIV;
            idx = k % DIGITS;
            es[idx] = 1'b1;
            eg = ~seg_tab[digit_of(m_hist[SCAN_DIV * (k + 1)], idx)];
        end
        chk("value",   value,   to_bcd(m_val));
        chk("shown",   shown,   to_bcd(shown_int()));
        chk("running", running, m_run);
        chk("wrap",    wrap,    m_wrap);
        chk("done",    done,    m_done);
        chk("dig_sel", dig_sel, es);
        chk("seg",     seg,     eg);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    bit seen;
    int exp_v;

    initial begin
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_seg", seg, 7'h7F);
        chk("rst_sel", dig_sel, 0);
        chk("rst_val", value, 0);

        // Up count from idle, then a full 100-tick wrap
        start = 1; step(); start = 0;
        chk("start_run", running, 1);
        repeat (3) step();
        chk("pre_tick", value, 8'h00);
        step();
        chk("first_tick", value, 8'h01);
        seen = 0;
        for (int i = 0; i < 420; i++) begin
            step();
            if (wrap) begin
                seen = 1;
                chk("wrap_val", value, 8'h00);
                chk("wrap_run", running, 1);
            end
        end
        chk("wrap_seen", seen, 1);

        // Down count to zero
        clear = 1; step(); clear = 0;
        load_value = 8'h03; load = 1; down = 1; step(); load = 0;
        chk("load03", value, 8'h03);
        start = 1; step(); start = 0;
        chk("dn_run", running, 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) begin
                seen = 1;
                chk("done_val", value, 8'h00);
                chk("done_run", running, 0);
            end
        end
        chk("done_seen", seen, 1);
        start = 1; step(); start = 0;
        chk("start_zero_ign", running, 0);

        // stop beats start; stop in the tick cycle freezes value
        down = 0;
        start = 1; step(); start = 0;
        repeat (2) step();
        stop = 1; start = 1; step(); stop = 0; start = 0;
        chk("stop_start", running, 0);
        start = 1; step(); start = 0;
        for (int i = 0; i < 8 && m_presc != TICK_DIV - 1; i++) step();
        exp_v = to_bcd(m_val);
        stop = 1; step(); stop = 0;
        chk("stop_tick_val", value, exp_v);
        chk("stop_tick_run", running, 0);

        // Lap hold while running
        start = 1; step(); start = 0;
        load_value = 8'h42; load = 1; step(); load = 0;
        lap = 1; step(); lap = 0;
        chk("lap_shown", shown, 8'h42);
        repeat (9) step();
        chk("lap_hold", shown, 8'h42);
        chk("lap_val", value, 8'h44);
        step();
        chk("lap_end", shown, 8'h45);

        // clear beats load mid-run; digit clamp on load
        lap = 1; step(); lap = 0;
        clear = 1; load = 1; load_value = 8'h77; step(); clear = 0; load = 0;
        chk("clr_val", value, 8'h00);
        chk("clr_run", running, 0);
        chk("clr_shown", shown, 8'h00);
        load_value = 8'h9C; load = 1; step(); load = 0;
        chk("clamp", value, 8'h99);

        // Scanner with 57 displayed
        load_value = 8'h57; load = 1; step(); load = 0;
        repeat (9) step();
        for (int i = 0; i < 16; i++) begin
            step();
            chk("seg57", seg, (dig_sel == 2'b01) ? 7'b1111000 :
                              (dig_sel == 2'b10) ? 7'b0010010 : 7'h00);
        end

        // Random command mix
        for (int i = 0; i < 2500; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            start      = ($urandom_range(0, 7) == 0);
            stop       = ($urandom_range(0, 23) == 0);
            clear      = ($urandom_range(0, 79) == 0);
            load       = ($urandom_range(0, 39) == 0);
            lap        = ($urandom_range(0, 19) == 0);
            load_value = VW'($urandom);
            if ($urandom_range(0, 49) == 0) down = ~down;
            step();
        end
        {rst, start, stop, clear, load, lap} = '0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_timer.md
# bcd_timer

Parametrised N-digit BCD stopwatch/countdown timer with a built-in multiplexed seven-segment scanner. It counts up or down at a prescaled tick and takes start, stop, clear, load and lap commands. It drives one active-low segment bus plus a one-hot digit select, which makes it the generalised timer core for badge Pmod display projects.

## Interface
- DIGITS, 4: number of BCD digits, 1..8
- TICK_DIV, 800000: clk cycles per count tick, >= 2
- LAP_HOLD, 20: ticks for which a captured lap value is displayed, >= 1
- SCAN_DIV, 1024: clk cycles per display digit slot, >= 2
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start, stop, clear, lap, load  in  1 each  commands, sampled every cycle
- down  in  1  0 = count up, 1 = count down
- load_value  in  4*DIGITS  preset, digit i at [4i+3:4i]
- value  out  4*DIGITS  current count (BCD)
- shown  out  4*DIGITS  displayed value (lap or count)
- running  out  1  timer active
- wrap  out  1  one-cycle pulse on up-count 99..9 -> 0
- done  out  1  one-cycle pulse on down-count reaching 0
- seg  out  7  active-low segments, bit0 = a … bit6 = g
- dig_sel  out  DIGITS  one-hot active-high digit enable

## Operation
- Prescaler counts 0..TICK_DIV-1 and free-runs. The tick is asserted in the cycle it equals TICK_DIV-1. A start accepted while idle zeroes it.
- Per-cycle command priority is rst > clear > load > stop > start > tick.
- clear: value = 0, running = 0, lap hold = 0.
- load: value = load_value. Any digit > 9 is clamped to 9. running is unchanged.
- stop: running = 0. Stop wins over a simultaneous start or tick, so no count occurs in that cycle.
- start while idle: running = 1. It is ignored when down = 1 and value == 0. Start while running has no effect.
- Tick with running, up mode: BCD increment with a ripple carry. All-9s becomes 0, wrap pulses, and running stays 1.
- Tick with running, down mode: BCD decrement with a ripple borrow. On reaching 0, done pulses and running = 0.
- A change of down mid-run applies at the next tick.
- lap: the lap register captures value as it was before any same-cycle update, and hold = LAP_HOLD.
  - Lap during an active hold re-captures and restarts the hold.
  - hold decrements on every tick regardless of running.
- shown = (hold != 0) ? lap register : value.
- Scanner:
  - Scan counter runs 0..SCAN_DIV-1.
  - On wrap, the digit index advances 0..DIGITS-1 with wraparound.
  - dig_sel and seg are registered from the selected digit of shown.
  - Segment encoding is the package table (digits 0-9), inverted.

## Timing
- Reset values:
  - value 0, running 0, wrap 0, done 0, hold 0, lap register 0.
  - Prescaler 0, scan counter 0, digit index 0.
  - dig_sel 0, seg 7'h7F (blank).
- value, running, wrap, done, seg and dig_sel are registered. shown is combinational from registers.
- Start at cycle t from idle:
  - running = 1 at t+1.
  - First tick at t+TICK_DIV; the updated value is visible at t+TICK_DIV+1.
- wrap and done assert in the same cycle the new value appears.
- Commands take effect one cycle after being sampled.
- Scanner:
  - First dig_sel = 1 appears SCAN_DIV+1 cycles after reset release.
  - Thereafter dig_sel changes every SCAN_DIV cycles.
  - seg updates in the same cycle as dig_sel.
- rst mid-run returns everything to reset values in the next cycle, including a pending pulse.

## Structure
- Package bcd_timer_pkg holds:
  - DIG_W = 4.
  - SEG_DIGIT[0:9], active-high a..g (0 = 7'b0111111, 5 = 7'b1101101, 7 = 7'b0000111).
  - SEG_BLANK.
- Sub-module bcd_step: combinational single-digit ±1 with carry/borrow in and out. It is instantiated DIGITS times as a chain, and digit 0's carry-in is the gated tick.

## Test plan
All scenarios use DIGITS=2, TICK_DIV=4, LAP_HOLD=3, SCAN_DIV=4.
- Reset, then start at t -> running=1 at t+1, value=0x01 at t+5. Running 100 ticks gives 0x99 -> 0x00 with a one-cycle wrap, and running stays 1.
- load 0x03, down=1, start -> 02, 01, 00. done pulses with value=0x00 and running=0. A second start is ignored.
- stop+start in the same cycle while running -> running=0. stop in the tick cycle -> value unchanged.
- lap at value 0x42 while running -> shown=0x42 for 3 ticks while value goes 43, 44, 45. shown then tracks value.
- clear+load in the same cycle mid-run -> value=0x00, running=0, hold 0. Separately, load 0x9C -> value=0x99.
- load 0x57, idle -> dig_sel alternates 01/10 every 4 cycles. seg=7'b1111000 with 01 and 7'b0010010 with 10.
